// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and imem (slave).
// Single outstanding request: req&ready accepts, valid returns the word later.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at
// a time and loads each fetched word plus its address into the IF/ID register.
//
// state | meaning
// FETCH | request at pc is offered to imem
// WAIT  | request accepted, waiting for its response (drop set = response is stale)
// HOLD  | response arrived under stall, parked in skid until decode frees up
// HALT  | fetch stopped; only reset leaves
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'd10000,
    parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_control,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid,
    output logic        halt_fetch
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic [31:0] skid_insn, skid_insn_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic        drop, drop_n;
    logic        deliver;
    logic [31:0] del_insn, del_pc;
    logic [31:0] redirect_tgt;
    logic        accept;

    assign redirect_tgt   = redirect_pc & ~32'd3;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = reset && (state == FETCH) && !redirect && !halt_control;
    assign accept         = imem.imem_req && imem.imem_ready;

    // Next-state and delivery decode; halt_control outranks redirect, which outranks fetch.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        skid_insn_n = skid_insn;
        skid_pc_n   = skid_pc;
        drop_n      = drop;
        deliver     = 1'b0;
        del_insn    = '0;
        del_pc      = '0;
        case (state)
            FETCH: begin
                if (halt_control) begin
                    state_n = HALT;
                end else if (redirect) begin
                    pc_n = redirect_tgt;
                end else if (accept) begin
                    pend_pc_n = pc;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if (halt_control) begin
                    state_n = HALT;
                    drop_n  = 1'b0;
                end else if (imem.imem_valid) begin
                    if (drop || redirect) begin
                        drop_n  = 1'b0;
                        state_n = FETCH;
                        if (redirect) pc_n = redirect_tgt;
                    end else if (stall) begin
                        skid_insn_n = imem.imem_rdata;
                        skid_pc_n   = pend_pc;
                        state_n     = HOLD;
                    end else begin
                        deliver  = 1'b1;
                        del_insn = imem.imem_rdata;
                        del_pc   = pend_pc;
                        pc_n     = pend_pc + 32'd4;
                        state_n  = FETCH;
                    end
                end else if (redirect) begin
                    // old request still in flight: remember to discard its response
                    pc_n   = redirect_tgt;
                    drop_n = 1'b1;
                end
            end
            HOLD: begin
                if (halt_control) begin
                    state_n = HALT;
                end else if (redirect) begin
                    pc_n    = redirect_tgt;
                    state_n = FETCH;
                end else if (!stall) begin
                    deliver  = 1'b1;
                    del_insn = skid_insn;
                    del_pc   = skid_pc;
                    pc_n     = skid_pc + 32'd4;
                    state_n  = FETCH;
                end
            end
            HALT: begin
            end
            default: state_n = FETCH;
        endcase
        if (deliver && (del_insn == HALT_INSN)) state_n = HALT;
    end

    // State, PC, skid and IF/ID register; IF/ID holds under stall, else loads or bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pend_pc     <= '0;
            skid_insn   <= '0;
            skid_pc     <= '0;
            drop        <= 1'b0;
            instruction <= '0;
            pc_out      <= '0;
            valid       <= 1'b0;
            halt_fetch  <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_pc   <= pend_pc_n;
            skid_insn <= skid_insn_n;
            skid_pc   <= skid_pc_n;
            drop      <= drop_n;
            if (!stall) begin
                valid       <= deliver;
                instruction <= deliver ? del_insn : 32'd0;
                if (deliver) pc_out <= del_pc;
            end
            if (deliver && (del_insn == HALT_INSN)) halt_fetch <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then
// randomized control/memory traffic checked every cycle against a
// transaction-level model of the fetch stage.
module tb_if_stage;
    localparam logic [31:0] RESET_PC  = 32'd10000;
    localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_control = 1'b0;
    logic [31:0] instruction, pc_out;
    logic        valid, halt_fetch;

    if_stage_if imem ();

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt_control (halt_control),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .valid        (valid),
        .halt_fetch   (halt_fetch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // stimulus knobs
    bit rand_ctl = 1'b0;
    int p_ready = 100, lat_max = 1, lat_fix = 1;
    int p_stall = 0, p_redir = 0, p_hc = 0, p_rst = 0, p_haltw = 0;

    // memory responder
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_word = '0;
    logic [31:0] script[$];
    bit          dut_acc = 1'b0;

    // behavioural model: what is in flight, what is parked, where the PC points
    logic [31:0] m_pc = RESET_PC;
    bit          m_busy = 0, m_stale = 0, m_held = 0, m_halted = 0;
    logic [31:0] m_ba = '0, m_hw = '0, m_ha = '0;
    bit          m_valid = 0, m_hf = 0;
    logic [31:0] m_insn = '0, m_pcout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return reset && !m_halted && !m_busy && !m_held && !redirect && !halt_control;
    endfunction

    task automatic model_step();
        bit          dlv;
        logic [31:0] dw, da;
        bit          req;
        req = model_req();
        dlv = 0; dw = '0; da = '0;
        if (!reset) begin
            m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_held = 0; m_halted = 0;
            m_valid = 0; m_insn = '0; m_pcout = '0; m_hf = 0;
        end else begin
            if (!m_halted) begin
                if (halt_control) begin
                    m_halted = 1; m_busy = 0; m_stale = 0; m_held = 0;
                end else begin
                    if (m_busy && imem.imem_valid) begin
                        m_busy = 0;
                        if (!m_stale && !redirect) begin
                            if (stall) begin
                                m_held = 1; m_hw = imem.imem_rdata; m_ha = m_ba;
                            end else begin
                                dlv = 1; dw = imem.imem_rdata; da = m_ba;
                            end
                        end
                        m_stale = 0;
                    end else if (m_busy && redirect) begin
                        m_stale = 1;
                    end else if (m_held) begin
                        if (redirect) m_held = 0;
                        else if (!stall) begin
                            dlv = 1; dw = m_hw; da = m_ha; m_held = 0;
                        end
                    end
                    if (req && imem.imem_ready) begin
                        m_busy = 1; m_ba = m_pc;
                    end
                    if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
                    if (dlv) begin
                        m_pc = da + 32'd4;
                        if (dw == HALT_INSN) begin
                            m_halted = 1; m_hf = 1;
                        end
                    end
                end
            end
            if (!stall) begin
                m_valid = dlv;
                m_insn  = dlv ? dw : 32'd0;
                if (dlv) m_pcout = da;
            end
        end
    endtask

    task automatic mem_step();
        if (imem.imem_valid) mem_busy = 0;
        if (dut_acc) begin
            mem_busy = 1;
            mem_wait = ((lat_fix > 0) ? lat_fix : int'($urandom_range(lat_max, 1))) - 1;
            if (script.size() > 0) mem_word = script.pop_front();
            else if ($urandom_range(99) < p_haltw) mem_word = HALT_INSN;
            else mem_word = $urandom;
        end
    endtask

    task automatic drive_inputs();
        if (rand_ctl) begin
            reset        = !($urandom_range(99) < p_rst);
            stall        = $urandom_range(99) < p_stall;
            redirect     = $urandom_range(99) < p_redir;
            redirect_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
            halt_control = $urandom_range(99) < p_hc;
        end
        if (mem_busy && mem_wait == 0) begin
            imem.imem_valid = 1'b1;
            imem.imem_rdata = mem_word;
        end else begin
            if (mem_busy) mem_wait--;
            imem.imem_valid = 1'b0;
            imem.imem_rdata = $urandom;
        end
        imem.imem_ready = !mem_busy && ($urandom_range(99) < p_ready);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            mem_step();
            #1;
            drive_inputs();
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, valid}, {31'd0, m_valid});
            chk("instruction", instruction, m_insn);
            chk("pc_out", pc_out, m_pcout);
            chk("halt_fetch", {31'd0, halt_fetch}, {31'd0, m_hf});
            chk("imem_req", {31'd0, imem.imem_req}, {31'd0, model_req()});
            chk("imem_addr", imem.imem_addr, m_pc);
        end
        dut_acc = imem.imem_req & imem.imem_ready;
    end

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_valid = 1'b0;
        imem.imem_rdata = '0;

        // reset and zero-wait sequential fetch
        script.push_back(32'h0000_0000);
        script.push_back(32'h3c1c_0000);
        script.push_back(32'h279c_0000);
        run(2);
        chk_en = 1'b1;
        reset = 1'b1;
        imem.imem_ready = 1'b1;
        settle();
        chk("t1_req", {31'd0, imem.imem_req}, 32'd1);
        chk("t1_addr", imem.imem_addr, 32'd10000);
        chk("t1_model_req", {31'd0, model_req()}, 32'd1);
        run(2); settle();
        chk("t1_v0", {31'd0, valid}, 32'd1);
        chk("t1_pc0", pc_out, 32'd10000);
        chk("t1_i0", instruction, 32'h0);
        chk("t1_addr1", imem.imem_addr, 32'd10004);
        chk("t1_model_pc0", m_pcout, 32'd10000);
        run(2); settle();
        chk("t1_pc1", pc_out, 32'd10004);
        chk("t1_i1", instruction, 32'h3c1c_0000);
        run(2); settle();
        chk("t1_pc2", pc_out, 32'd10008);
        chk("t1_i2", instruction, 32'h279c_0000);
        chk("t1_v2", {31'd0, valid}, 32'd1);
        chk("t1_addr3", imem.imem_addr, 32'd10012);

        // stall across WAIT and HOLD
        script.push_back(32'h3c1c_0000);
        stall = 1'b1;
        run(1); settle();
        chk("t2_req_wait", {31'd0, imem.imem_req}, 32'd0);
        run(2); settle();
        chk("t2_hold_i", instruction, 32'h279c_0000);
        chk("t2_hold_pc", pc_out, 32'd10008);
        chk("t2_hold_req", {31'd0, imem.imem_req}, 32'd0);
        stall = 1'b0;
        run(1); settle();
        chk("t2_i", instruction, 32'h3c1c_0000);
        chk("t2_pc", pc_out, 32'd10012);
        chk("t2_addr", imem.imem_addr, 32'd10016);

        // redirect while the request is in flight
        lat_fix = 2;
        script.push_back(32'h1111_1111);
        run(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0403;
        settle();
        chk("t3_req_redir", {31'd0, imem.imem_req}, 32'd0);
        run(1);
        redirect = 1'b0;
        settle();
        chk("t3_ifid_v", {31'd0, valid}, 32'd0);
        chk("t3_ifid_pc", pc_out, 32'd10012);
        chk("t3_addr", imem.imem_addr, 32'h0000_0400);
        chk("t3_req_drop", {31'd0, imem.imem_req}, 32'd0);
        run(1); settle();
        chk("t3_req_new", {31'd0, imem.imem_req}, 32'd1);
        chk("t3_addr_new", imem.imem_addr, 32'h0000_0400);
        chk("t3_no_deliver", {31'd0, valid}, 32'd0);

        // halt instruction fetched
        lat_fix = 1;
        script.push_back(HALT_INSN);
        run(2); settle();
        chk("t4_v", {31'd0, valid}, 32'd1);
        chk("t4_pc", pc_out, 32'h0000_0400);
        chk("t4_i", instruction, HALT_INSN);
        chk("t4_hf", {31'd0, halt_fetch}, 32'd1);
        chk("t4_req", {31'd0, imem.imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0800;
        run(2);
        redirect = 1'b0;
        settle();
        chk("t4_req_after", {31'd0, imem.imem_req}, 32'd0);
        chk("t4_addr_after", imem.imem_addr, 32'h0000_0404);
        chk("t4_hf_after", {31'd0, halt_fetch}, 32'd1);
        chk("t4_drain", {31'd0, valid}, 32'd0);

        // halt_control with the skid occupied
        reset = 1'b0;
        settle();
        chk("t5_req_rst", {31'd0, imem.imem_req}, 32'd0);
        run(1);
        reset = 1'b1;
        settle();
        chk("t5_rst_addr", imem.imem_addr, RESET_PC);
        chk("t5_rst_hf", {31'd0, halt_fetch}, 32'd0);
        chk("t5_rst_pc", pc_out, 32'd0);
        script.push_back(32'h1234_5678);
        run(1);
        stall = 1'b1;
        run(1);
        halt_control = 1'b1;
        settle();
        chk("t5_req_hc", {31'd0, imem.imem_req}, 32'd0);
        run(1);
        halt_control = 1'b0;
        stall = 1'b0;
        run(2); settle();
        chk("t5_req", {31'd0, imem.imem_req}, 32'd0);
        chk("t5_v", {31'd0, valid}, 32'd0);
        chk("t5_i", instruction, 32'd0);
        chk("t5_hf", {31'd0, halt_fetch}, 32'd0);
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        settle();
        chk("t5_restart_req", {31'd0, imem.imem_req}, 32'd1);
        chk("t5_restart_addr", imem.imem_addr, RESET_PC);

        // PC wrap-around
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        settle();
        chk("t6_req_redir", {31'd0, imem.imem_req}, 32'd0);
        run(1);
        redirect = 1'b0;
        settle();
        chk("t6_addr", imem.imem_addr, 32'hFFFF_FFFC);
        chk("t6_req", {31'd0, imem.imem_req}, 32'd1);
        script.push_back(32'hAAAA_0001);
        run(2); settle();
        chk("t6_pc", pc_out, 32'hFFFF_FFFC);
        chk("t6_i", instruction, 32'hAAAA_0001);
        chk("t6_wrap", imem.imem_addr, 32'h0000_0000);

        // randomized traffic
        lat_fix = 0;
        rand_ctl = 1'b1;
        p_ready = 100; lat_max = 1; p_stall = 0;  p_redir = 0;  p_hc = 0; p_rst = 0; p_haltw = 0;
        run(400);
        p_ready = 70;  lat_max = 3; p_stall = 30; p_redir = 5;  p_hc = 0; p_rst = 1; p_haltw = 0;
        run(1500);
        p_ready = 60;  lat_max = 3; p_stall = 25; p_redir = 10; p_hc = 2; p_rst = 3; p_haltw = 3;
        run(1500);
        p_ready = 90;  lat_max = 2; p_stall = 50; p_redir = 3;  p_hc = 1; p_rst = 2; p_haltw = 5;
        run(1500);
        rand_ctl = 1'b0;
        @(posedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
